pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register: successor to the fixed three-field fetch/decode register with flush/stall.
- Carries NFIELDS fields of WIDTH bits with valid/ready handshake in place of a raw stall.
- Optional 2-entry skid buffer so upstream ready is registered, not combinational.
- Flush inserts a bubble; saturating stall/flush counters for performance debug. Drop-in between any two core stages (F/D, D/E, ...).

Parameters:
- WIDTH, 32, bits per field.
- NFIELDS, 3, number of fields (e.g. instr, pc, pcplus4).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- BUBBLE_VAL, 0, WIDTH-bit value written into every field on flush or drain.
- CNT_W, 16, counter width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries and any same-cycle input.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  NFIELDS*WIDTH  field k at [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NFIELDS*WIDTH  registered output fields.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating.
- flush_cnt  out  CNT_W  flush cycles that discarded at least one valid entry or input, saturating.

Behaviour:
- Reset (rst=1 at posedge): state EMPTY, out_valid=0, every out_data field=BUBBLE_VAL, skid cleared, both counters 0. While rst=1, in_ready=0.
- acc = in_valid && in_ready; con = out_valid && out_ready. Latency 1 cycle; strict FIFO order; no duplication, no loss except via flush.
- out_data stable while out_valid && !out_ready.
- SKID=1 states:
  - EMPTY (out_valid=0, in_ready=1): acc -> FULL, main<=in_data.
  - FULL (out_valid=1, in_ready=1):
    - con&&acc -> FULL, main<=in_data.
    - con only -> EMPTY, main<=bubble.
    - acc only -> SKIDDED, skid<=in_data.
    - neither -> hold.
  - SKIDDED (out_valid=1, in_ready=0): con -> FULL, main<=skid, skid cleared; else hold.
  - in_ready is a pure decode of registered state.
- SKID=0: in_ready = !out_valid || out_ready (combinational). acc loads main; con without acc -> out_valid=0, main<=bubble.
- Flush (rst=0, flush=1): overrides all handshake activity.
  - Next state EMPTY; out_valid=0; main and skid fields <= BUBBLE_VAL.
  - Same-cycle input dropped even if acc. in_ready unaffected that cycle, but any acc is discarded.
- Priority: rst > flush > handshake.
- stall_cnt: +1 per cycle with out_valid && !out_ready && !flush; holds at 2^CNT_W-1.
- flush_cnt: +1 per flush cycle where out_valid || (SKID && skid valid) || in_valid; saturates.
- Reset mid-transfer: all held data lost, counters zeroed, no output pulse.

Decomposition:
- Shared package pipe_pkg: state enum {EMPTY, FULL, SKIDDED}, default BUBBLE_VAL, CNT_W default, field-slice helper function.
- One natural sub-module: sat_counter (CNT_W, inc, rst, count), instantiated twice.
- Skid/main storage stays inline.

Test Plan:
- Reset then stream: NFIELDS=3; after rst, in_valid=1 with fields {0x13,0x100,0x104}, out_ready=1 -> out_valid=1 next cycle with same fields. in_ready=1 throughout; stall_cnt=0.
- Backpressure/skid (SKID=1): out_ready=0; send A then B -> out=A, skid=B, in_ready=0 on 3rd cycle. stall_cnt counts 1,2,... Raise out_ready -> A, then B, in order, no loss.
- Flush while SKIDDED with in_valid=1 C: next cycle out_valid=0, all fields=BUBBLE_VAL, in_ready=1, flush_cnt=1; C never appears.
- Flush with nothing valid (out_valid=0, in_valid=0) -> flush_cnt unchanged, state EMPTY.
- SKID=0 full throughput: out_ready=1, 8 back-to-back inputs 0..7 -> outputs 0..7 on consecutive cycles. out_ready=0 -> in_ready=0 same cycle.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays. rst mid-stall -> stall_cnt=0, out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the parametrised pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_e;

  localparam int          DEF_CNT_W      = 16;
  localparam logic [31:0] DEF_BUBBLE_VAL = 32'h0000_0000;

  // Bit offset of field k inside a packed NFIELDS*w bus.
  function automatic int field_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; cleared by synchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage carrying NFIELDS fields, with optional skid entry,
// flush-to-bubble and saturating stall/flush counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NFIELDS    = 3,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(DEF_BUBBLE_VAL),
  parameter int               CNT_W      = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NFIELDS*WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NFIELDS*WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int DW = NFIELDS * WIDTH;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic [DW-1:0] bubble_vec;

  logic acc;
  logic con;
  logic skid_valid;
  logic stall_inc;
  logic flush_inc;

  for (genvar gi = 0; gi < NFIELDS; gi++) begin : g_bubble
    assign bubble_vec[field_lsb(gi, WIDTH) +: WIDTH] = BUBBLE_VAL;
  end

  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_q;
  assign skid_valid = (state_q == SKIDDED);

  // With the skid entry, upstream ready depends only on held state, never on out_ready.
  always_comb begin
    if (SKID != 0) begin
      in_ready = !rst && (state_q != SKIDDED);
    end else begin
      in_ready = !rst && (!out_valid || out_ready);
    end
  end

  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = bubble_vec;
      skid_d  = bubble_vec;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (con && acc) begin
            main_d = in_data;
          end else if (con) begin
            state_d = EMPTY;
            main_d  = bubble_vec;
          end else if (acc) begin
            if (SKID != 0) begin
              state_d = SKIDDED;
              skid_d  = in_data;
            end else begin
              main_d = in_data;
            end
          end
        end
        SKIDDED: begin
          if (con) begin
            state_d = FULL;
            main_d  = skid_q;
            skid_d  = bubble_vec;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = bubble_vec;
          skid_d  = bubble_vec;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= bubble_vec;
      skid_q  <= bubble_vec;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A flush only counts when it actually threw something away.
  assign stall_inc = out_valid && !out_ready && !flush;
  assign flush_inc = flush && (out_valid || ((SKID != 0) && skid_valid) || in_valid);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: instance a (SKID=1, CNT_W=4, nonzero bubble), instance b (SKID=0).
module tb_pipe_stage_buf;

  localparam int WIDTH = 32;
  localparam int NF    = 3;
  localparam int DW    = WIDTH * NF;
  localparam logic [WIDTH-1:0] BUB_A = 32'hB0B0_B0B0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [DW-1:0] in_data_a, out_data_a;
  logic [3:0]    stall_cnt_a, flush_cnt_a;

  logic          flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [DW-1:0] in_data_b, out_data_b;
  logic [15:0]   stall_cnt_b, flush_cnt_b;

  pipe_stage_buf #(.WIDTH(WIDTH), .NFIELDS(NF), .SKID(1), .BUBBLE_VAL(BUB_A), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_stage_buf #(.WIDTH(WIDTH), .NFIELDS(NF), .SKID(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] bub3_a;

  task automatic chk(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Scoreboard: at negedge, record accepted inputs and check consumed outputs, then step one edge.
  task automatic cycle();
    @(negedge clk);
    if (rst || flush_a) begin
      q_a.delete();
    end else begin
      if (out_valid_a && out_ready_a) begin
        if (q_a.size() == 0) chk("a_pop_unexpected", out_data_a, '0 ^ {DW{1'bx}});
        else chk("a_out_order", out_data_a, q_a.pop_front());
      end
      if (in_valid_a && in_ready_a) q_a.push_back(in_data_a);
    end
    if (rst || flush_b) begin
      q_b.delete();
    end else begin
      if (out_valid_b && out_ready_b) begin
        if (q_b.size() == 0) chk("b_pop_unexpected", out_data_b, '0 ^ {DW{1'bx}});
        else chk("b_out_order", out_data_b, q_b.pop_front());
      end
      if (in_valid_b && in_ready_b) q_b.push_back(in_data_b);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack3(input logic [31:0] f2, input logic [31:0] f1, input logic [31:0] f0);
    return {f2, f1, f0};
  endfunction

  initial begin
    bub3_a = {BUB_A, BUB_A, BUB_A};
    rst = 1'b1;
    flush_a = 0; in_valid_a = 0; in_data_a = '0; out_ready_a = 0;
    flush_b = 0; in_valid_b = 0; in_data_b = '0; out_ready_b = 1;
    in_valid_a = 1'b1;
    cycle();
    cycle();
    $display("reset: in_ready=%0b out_valid=%0b", in_ready_a, out_valid_a);
    chk("rst_in_ready", DW'(in_ready_a), DW'(1'b0));
    chk("rst_out_valid", DW'(out_valid_a), DW'(1'b0));
    chk("rst_out_data", out_data_a, bub3_a);
    chk("rst_stall", DW'(stall_cnt_a), DW'(0));
    chk("rst_flush", DW'(flush_cnt_a), DW'(0));
    in_valid_a = 0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", DW'(in_ready_a), DW'(1'b1));

    // Stream one entry through with downstream ready.
    in_valid_a = 1; out_ready_a = 1; in_data_a = pack3(32'h104, 32'h100, 32'h13);
    cycle();
    $display("stream: out_valid=%0b out_data=%h", out_valid_a, out_data_a);
    chk("stream_valid", DW'(out_valid_a), DW'(1'b1));
    chk("stream_data", out_data_a, pack3(32'h104, 32'h100, 32'h13));
    chk("stream_in_ready", DW'(in_ready_a), DW'(1'b1));
    in_valid_a = 0;
    cycle();
    chk("drain_valid", DW'(out_valid_a), DW'(1'b0));
    chk("drain_bubble", out_data_a, bub3_a);
    chk("stream_stall", DW'(stall_cnt_a), DW'(0));

    // Backpressure: A into main, B into skid.
    out_ready_a = 0; in_valid_a = 1; in_data_a = pack3(32'hA2, 32'hA1, 32'hA0);
    cycle();
    in_data_a = pack3(32'hB2, 32'hB1, 32'hB0);
    cycle();
    $display("skid: in_ready=%0b out_data=%h stall=%0d", in_ready_a, out_data_a, stall_cnt_a);
    chk("skid_in_ready", DW'(in_ready_a), DW'(1'b0));
    chk("skid_out_data", out_data_a, pack3(32'hA2, 32'hA1, 32'hA0));
    chk("skid_stall1", DW'(stall_cnt_a), DW'(1));
    in_valid_a = 0;
    cycle();
    chk("skid_hold_data", out_data_a, pack3(32'hA2, 32'hA1, 32'hA0));
    chk("skid_stall2", DW'(stall_cnt_a), DW'(2));
    out_ready_a = 1;
    cycle();
    chk("skid_second", out_data_a, pack3(32'hB2, 32'hB1, 32'hB0));
    cycle();
    chk("skid_drained", DW'(out_valid_a), DW'(1'b0));
    chk("skid_queue_empty", DW'(q_a.size()), DW'(0));

    // Flush while SKIDDED with a same-cycle input C.
    out_ready_a = 0; in_valid_a = 1; in_data_a = pack3(32'hD2, 32'hD1, 32'hD0);
    cycle();
    in_data_a = pack3(32'hE2, 32'hE1, 32'hE0);
    cycle();
    flush_a = 1; in_data_a = pack3(32'hC2, 32'hC1, 32'hC0);
    cycle();
    $display("flush: out_valid=%0b in_ready=%0b flush_cnt=%0d", out_valid_a, in_ready_a, flush_cnt_a);
    chk("flush_valid", DW'(out_valid_a), DW'(1'b0));
    chk("flush_bubble", out_data_a, bub3_a);
    chk("flush_in_ready", DW'(in_ready_a), DW'(1'b1));
    chk("flush_cnt1", DW'(flush_cnt_a), DW'(1));
    chk("flush_stall", DW'(stall_cnt_a), DW'(3));
    flush_a = 0; in_valid_a = 0; out_ready_a = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("flush_no_c", DW'(out_valid_a), DW'(1'b0));

    // Flush with nothing valid is not counted.
    flush_a = 1;
    cycle();
    flush_a = 0;
    chk("idle_flush_cnt", DW'(flush_cnt_a), DW'(1));
    chk("idle_flush_empty", DW'(out_valid_a), DW'(1'b0));

    // Stall counter saturation at 4 bits, then reset mid-stall.
    out_ready_a = 0; in_valid_a = 1; in_data_a = pack3(32'hF2, 32'hF1, 32'hF0);
    cycle();
    in_valid_a = 0;
    for (int i = 0; i < 20; i++) cycle();
    $display("saturate: stall_cnt=%0d", stall_cnt_a);
    chk("sat_15", DW'(stall_cnt_a), DW'(15));
    for (int i = 0; i < 3; i++) cycle();
    chk("sat_hold", DW'(stall_cnt_a), DW'(15));
    chk("sat_data_stable", out_data_a, pack3(32'hF2, 32'hF1, 32'hF0));
    rst = 1;
    cycle();
    rst = 0;
    $display("mid-stall reset: stall_cnt=%0d out_valid=%0b", stall_cnt_a, out_valid_a);
    chk("rst_mid_stall", DW'(stall_cnt_a), DW'(0));
    chk("rst_mid_valid", DW'(out_valid_a), DW'(1'b0));
    chk("rst_mid_flush", DW'(flush_cnt_a), DW'(0));

    // SKID=0: eight back-to-back transfers at full rate.
    out_ready_b = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid_b = 1; in_data_b = pack3(32'(i + 100), 32'(i + 10), 32'(i));
      #1;
      chk("b_in_ready", DW'(in_ready_b), DW'(1'b1));
      cycle();
      $display("b xfer %0d: out_valid=%0b out_data=%h", i, out_valid_b, out_data_b);
      chk("b_out_now", out_data_b, pack3(32'(i + 100), 32'(i + 10), 32'(i)));
    end
    in_valid_b = 0;
    cycle();
    chk("b_drained", DW'(out_valid_b), DW'(1'b0));
    in_valid_b = 1; in_data_b = pack3(32'h55, 32'h44, 32'h33);
    cycle();
    out_ready_b = 0;
    #1;
    chk("b_comb_ready_low", DW'(in_ready_b), DW'(1'b0));
    out_ready_b = 1;
    #1;
    chk("b_comb_ready_high", DW'(in_ready_b), DW'(1'b1));
    in_valid_b = 0;
    cycle();
    cycle();
    chk("b_queue_empty", DW'(q_b.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
